// File: rtl/mmio_uart_tx_if.sv
// Core data-memory store/load bus as seen by the UART transmitter.
// The core side drives strobes and addresses; the responder returns load data.
interface mmio_uart_tx_if;
  logic        write_mem;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output write_mem,
    output write_address,
    output write_data,
    output read_address,
    input  read_data,
    input  hit
  );

  modport slave (
    input  write_mem,
    input  write_address,
    input  write_data,
    input  read_address,
    output read_data,
    output hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
// TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4; tx idles high.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFF0,
  parameter int          CLKS_PER_BIT = 104
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] A_TXD = BASE_ADDR;
  localparam logic [31:0] A_STS = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]    mem_q [4];
  logic [1:0]    wptr_q, rptr_q;
  logic [2:0]    count_q;
  logic          ovf_q;

  logic wr_txd, wr_sts;
  logic push, pop;
  logic full, empty, busy, expire;
  logic [31:0] status;
  logic unused;

  assign wr_txd = bus.write_mem && (bus.write_address == A_TXD);
  assign wr_sts = bus.write_mem && (bus.write_address == A_STS);
  assign full   = (count_q == 3'd4);
  assign empty  = (count_q == 3'd0);
  // Decided on the pre-edge count, so a same-edge pop cannot make room.
  assign push   = wr_txd && !full;
  assign busy   = (state_q != S_IDLE);
  assign expire = (cnt_q == '0);
  assign unused = ^{bus.write_data[31:8]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = CNT_MAX;
          idx_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (expire) begin
          cnt_d   = CNT_MAX;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        tx = shift_q[0];
        if (expire) begin
          cnt_d   = CNT_MAX;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (expire) begin
          cnt_d = CNT_MAX;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            idx_d   = 3'd0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (wr_txd && full) begin
        ovf_q <= 1'b1;
      end else if (wr_sts && bus.write_data[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign status = {25'd0, count_q, ovf_q, empty, full, busy};

  always_comb begin
    bus.hit       = 1'b0;
    bus.read_data = 32'd0;
    unique case (1'b1)
      (bus.read_address == A_TXD): bus.hit = 1'b1;
      (bus.read_address == A_STS): begin
        bus.hit       = 1'b1;
        bus.read_data = status;
      end
      default: ;
    endcase
  end

endmodule
